mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory port between two cache controllers, port 0 = I-cache and port 1 = D-cache.
- Each controller issues write-back/fill transactions as one-cycle request pulses; the arbiter captures them, round-robins between pending ports and holds one outstanding memory transaction.
- It routes the memory response back to the owning port.
- Sits between the per-cache controllers and the memory model.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 128, transfer width (one cache line)
TIMEOUT_CYCLES, 255, WAIT cycles before timeout abort (used only with the optional feature)

Ports:
clk  in  1  clock; all state on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
req_valid0/1  in  1  one-cycle request pulse from port 0/1
req_wen0/1  in  1  1 = write-back, 0 = fill; sampled with req_valid
req_addr0/1  in  ADDR_WIDTH  request address; sampled with req_valid
req_wdata0/1  in  DATA_WIDTH  write data; sampled with req_valid
res_valid0/1  out  1  one-cycle completion pulse to port 0/1
res_rdata0/1  out  DATA_WIDTH  read data; held until next completion on that port
res_err0/1  out  1  timeout flag, qualified by res_valid
busy0/1  out  1  port has a captured, uncompleted request
mem_req_valid  out  1  one-cycle request pulse to memory
mem_req_wen  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_res_valid  in  1  memory completion pulse
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_res_valid

Behaviour:
- All outputs registered. Reset (rst=0, async) clears every output to 0, clears both pending slots, state=IDLE, last_grant=1 (port 0 wins first tie), timeout counter=0.
- Capture: each port has one pending slot (wen/addr/wdata).
  - req_valid sets the slot at the clock edge, visible on busy the next cycle.
  - A pulse while that slot is already busy is dropped; the slot is unchanged.
  - Both ports pulsing in the same cycle: both captured.
  - A pulse in the same cycle as that port's res_valid is captured; the slot clears and reloads.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any slot is pending, select owner and go to ISSUE. Only one pending: grant it. Both pending: grant the port != last_grant. Update last_grant to the owner.
  - ISSUE: for exactly one cycle, mem_req_valid=1 with mem_req_wen/mem_addr/mem_wdata from the owner slot. Next state WAIT.
  - WAIT: mem_addr/mem_wen/mem_wdata held; mem_req_valid=0. On mem_res_valid, go to IDLE: owner res_valid=1 for one cycle (next cycle), res_rdata<=mem_rdata for fills, unchanged for write-backs, res_err=0, owner slot cleared.
- mem_res_valid outside WAIT is ignored. Memory latency is ≥1 cycle after the mem_req_valid cycle.
- Latency, idle arbiter: req_valid at cycle 0 → busy=1 at cycle 1, FSM decides in cycle 1 → mem_req_valid in cycle 2 → mem_res_valid at cycle k≥3 → res_valid in cycle k+1.
- Back-to-back: IDLE lasts one cycle between transactions. Minimum spacing of mem_req_valid is 3 cycles.
- Non-owner port never sees res_valid; its busy stays 1 until its own completion.
- Reset mid-transaction drops everything. A mem_res_valid arriving after reset release is ignored (state IDLE).

Optional Feature:
Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without mem_res_valid, go to IDLE and complete the owner with res_valid=1, res_err=1, res_rdata=0, slot cleared.
  - A late mem_res_valid after this is ignored.
  - mem_res_valid in the same cycle the counter reaches the limit counts as a normal completion (err=0).
- Undefined: no counter; WAIT waits indefinitely; res_err0/1 are tied to 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → all outputs 0. With req_valid0=0/1 low, mem_req_valid stays 0 for 10 cycles.
- Single fill:
  - Stimulus: req_valid0 pulse at cycle 0 with addr=0x100, wen=0; memory returns rdata=0xDEADBEEF 4 cycles after the request.
  - Expected: mem_req_valid in cycle 2 with addr 0x100, wen=0; res_valid0 one cycle after mem_res_valid; res_rdata0=0xDEADBEEF; busy0 back to 0; res_valid1 never asserts.
- Simultaneous requests: req_valid0 (fill 0x200) and req_valid1 (write-back 0x300, wdata=0x55) in the same cycle → memory sees 0x200 first, then 0x300 with wen=1, wdata=0x55, each completed on the correct port. Repeat both → order alternates (port 1 first the second time).
- Drop and re-capture:
  - Second req_valid0 (addr 0x400) while busy0 → memory never sees 0x400.
  - req_valid1 pulsed in the same cycle as res_valid1 → captured, issued next.
- Reset mid-WAIT: assert rst during WAIT, release, then pulse mem_res_valid → no res_valid on either port, busy0/1=0, FSM accepts a new request normally.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: memory never responds → res_valid0=1, res_err0=1, res_rdata0=0 after 8 WAIT cycles. A later mem_res_valid is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one memory port between I-cache (port 0) and D-cache (port 1).
// Optional WAIT timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid0,
    input  logic                  req_wen0,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic                  req_valid1,
    input  logic                  req_wen1,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic                  res_valid0,
    output logic [DATA_WIDTH-1:0] res_rdata0,
    output logic                  res_err0,
    output logic                  res_valid1,
    output logic [DATA_WIDTH-1:0] res_rdata1,
    output logic                  res_err1,
    output logic                  busy0,
    output logic                  busy1,
    output logic                  mem_req_valid,
    output logic                  mem_req_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_res_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e                state_q;
    logic                  owner_q;
    logic                  last_q;
    logic [1:0]            slot_vld_q, slot_vld_d;
    logic [1:0]            slot_wen_q;
    logic [ADDR_WIDTH-1:0] slot_addr_q  [2];
    logic [DATA_WIDTH-1:0] slot_wdata_q [2];

    logic [1:0]            req_v, req_wen, capture;
    logic [ADDR_WIDTH-1:0] req_addr  [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];
    logic                  grant;
    logic                  done;

    logic                  mem_req_valid_q, mem_req_wen_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [1:0]            res_valid_q;
    logic [DATA_WIDTH-1:0] res_rdata_q [2];

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_hit;
    logic [1:0]       res_err_q;
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

    assign req_v        = {req_valid1, req_valid0};
    assign req_wen      = {req_wen1, req_wen0};
    assign req_addr[0]  = req_addr0;
    assign req_addr[1]  = req_addr1;
    assign req_wdata[0] = req_wdata0;
    assign req_wdata[1] = req_wdata1;

    always_comb begin
        // A pulse is only taken into an empty slot; a busy slot drops it.
        capture = req_v & ~slot_vld_q;
        grant   = (slot_vld_q == 2'b11) ? ~last_q : slot_vld_q[1];
        done    = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_hit = 1'b0;
`endif
        if (state_q == WAIT) begin
            if (mem_res_valid) begin
                done = 1'b1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
                done    = 1'b1;
                tmo_hit = 1'b1;
            end
`endif
        end
        slot_vld_d = slot_vld_q | capture;
        if (done) begin
            slot_vld_d[owner_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_vld_q <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (capture[p]) begin
                slot_wen_q[p]   <= req_wen[p];
                slot_addr_q[p]  <= req_addr[p];
                slot_wdata_q[p] <= req_wdata[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            last_q          <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_req_wen_q   <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            res_valid_q     <= '0;
            res_rdata_q[0]  <= '0;
            res_rdata_q[1]  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt_q       <= '0;
            res_err_q       <= '0;
`endif
        end else begin
            mem_req_valid_q <= 1'b0;
            res_valid_q     <= '0;
            case (state_q)
                IDLE: begin
                    if (|slot_vld_q) begin
                        owner_q         <= grant;
                        last_q          <= grant;
                        state_q         <= ISSUE;
                        mem_req_valid_q <= 1'b1;
                        mem_req_wen_q   <= slot_wen_q[grant];
                        mem_addr_q      <= slot_addr_q[grant];
                        mem_wdata_q     <= slot_wdata_q[grant];
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                WAIT: begin
                    if (done) begin
                        state_q              <= IDLE;
                        res_valid_q[owner_q] <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        res_err_q[owner_q] <= tmo_hit;
                        if (tmo_hit) begin
                            res_rdata_q[owner_q] <= '0;
                        end else if (!mem_req_wen_q) begin
                            res_rdata_q[owner_q] <= mem_rdata;
                        end
`else
                        if (!mem_req_wen_q) begin
                            res_rdata_q[owner_q] <= mem_rdata;
                        end
`endif
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy0         = slot_vld_q[0];
    assign busy1         = slot_vld_q[1];
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_wen   = mem_req_wen_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign res_valid0    = res_valid_q[0];
    assign res_valid1    = res_valid_q[1];
    assign res_rdata0    = res_rdata_q[0];
    assign res_rdata1    = res_rdata_q[1];
`ifdef MEM_ARB_TIMEOUT_EN
    assign res_err0      = res_err_q[0];
    assign res_err1      = res_err_q[1];
`else
    assign res_err0      = 1'b0;
    assign res_err1      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences, and randomized traffic
// against a transaction-level model of capture, round-robin grant and completion routing.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid0, req_wen0, req_valid1, req_wen1;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [DW-1:0] req_wdata0, req_wdata1;
    logic          res_valid0, res_err0, res_valid1, res_err1, busy0, busy1;
    logic [DW-1:0] res_rdata0, res_rdata1;
    logic          mem_req_valid, mem_req_wen, mem_res_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid0(req_valid0), .req_wen0(req_wen0), .req_addr0(req_addr0), .req_wdata0(req_wdata0),
        .req_valid1(req_valid1), .req_wen1(req_wen1), .req_addr1(req_addr1), .req_wdata1(req_wdata1),
        .res_valid0(res_valid0), .res_rdata0(res_rdata0), .res_err0(res_err0),
        .res_valid1(res_valid1), .res_rdata1(res_rdata1), .res_err1(res_err1),
        .busy0(busy0), .busy1(busy1),
        .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_res_valid(mem_res_valid), .mem_rdata(mem_rdata)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req_valid0    = 1'b0;
        req_valid1    = 1'b0;
        mem_res_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
    endtask

    function automatic logic get_rv(input int p);
        return (p == 0) ? res_valid0 : res_valid1;
    endfunction
    function automatic logic get_busy(input int p);
        return (p == 0) ? busy0 : busy1;
    endfunction
    function automatic logic get_err(input int p);
        return (p == 0) ? res_err0 : res_err1;
    endfunction
    function automatic logic [DW-1:0] get_rd(input int p);
        return (p == 0) ? res_rdata0 : res_rdata1;
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) chk("mem_req_wait_expired", 1'b0, 1'b1);
    endtask

    // Wait for the next memory request, check it, answer two cycles later, check the completion.
    task automatic serve(input int p, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic [DW-1:0] exp_rd);
        bit ok;
        wait_req(ok);
        chk("srv_addr", mem_addr, a);
        chk("srv_wen", mem_req_wen, w);
        if (w) chk("srv_wdata", mem_wdata, wd);
        step();
        chk("srv_req_one_cycle", mem_req_valid, 1'b0);
        step();
        mem_res_valid = 1'b1;
        mem_rdata     = rd;
        step();
        chk("srv_res_valid", get_rv(p), 1'b1);
        chk("srv_other_res_valid", get_rv(1 - p), 1'b0);
        chk("srv_rdata", get_rd(p), exp_rd);
        chk("srv_err", get_err(p), 1'b0);
        chk("srv_busy_clear", get_busy(p), 1'b0);
    endtask

    typedef struct {
        logic          rv0;
        logic [AW-1:0] a0;
        logic          mrv;
        logic [DW-1:0] mrd;
        logic          e_busy0;
        logic          e_mreq;
        logic [AW-1:0] e_maddr;
        logic          e_rv0;
        logic          e_rv1;
        logic [DW-1:0] e_rd0;
    } vec_t;
    vec_t tbl [9];

    // Reference model state
    logic          m_vld [2];
    int            m_cap [2];
    logic          m_wen [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rd [2];
    logic          m_resv [2];
    int            m_last, own, resp_at, free_from;
    bit            outst, el0, el1, exp_req, ok;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req_valid0 = 0; req_wen0 = 0; req_addr0 = '0; req_wdata0 = '0;
        req_valid1 = 0; req_wen1 = 0; req_addr1 = '0; req_wdata1 = '0;
        mem_res_valid = 0; mem_rdata = '0;

        tbl[0] = '{1'b1, 32'h100, 1'b0, 128'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 128'h0};
        tbl[1] = '{1'b0, 32'h0,   1'b0, 128'h0,        1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 128'h0};
        tbl[2] = '{1'b0, 32'h0,   1'b0, 128'h0,        1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 128'h0};
        tbl[3] = '{1'b0, 32'h0,   1'b0, 128'h0,        1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 128'h0};
        tbl[4] = '{1'b0, 32'h0,   1'b0, 128'h0,        1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 128'h0};
        tbl[5] = '{1'b0, 32'h0,   1'b0, 128'h0,        1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 128'h0};
        tbl[6] = '{1'b0, 32'h0,   1'b1, 128'hDEADBEEF, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 128'h0};
        tbl[7] = '{1'b0, 32'h0,   1'b0, 128'h0,        1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 128'hDEADBEEF};
        tbl[8] = '{1'b0, 32'h0,   1'b0, 128'h0,        1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 128'hDEADBEEF};

        // Reset state
        do_reset();
        chk("rst_busy0", busy0, 0);           chk("rst_busy1", busy1, 0);
        chk("rst_res_valid0", res_valid0, 0); chk("rst_res_valid1", res_valid1, 0);
        chk("rst_rdata0", res_rdata0, 0);     chk("rst_rdata1", res_rdata1, 0);
        chk("rst_err0", res_err0, 0);         chk("rst_err1", res_err1, 0);
        chk("rst_mem_req", mem_req_valid, 0); chk("rst_mem_wen", mem_req_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);     chk("rst_mem_wdata", mem_wdata, 0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_mem_req", mem_req_valid, 0);
            step();
        end

        // Single fill on port 0, cycle by cycle
        for (int i = 0; i < 9; i++) begin
            chk("tbl_busy0", busy0, tbl[i].e_busy0);
            chk("tbl_mem_req", mem_req_valid, tbl[i].e_mreq);
            chk("tbl_mem_addr", mem_addr, tbl[i].e_maddr);
            if (tbl[i].e_mreq) chk("tbl_mem_wen", mem_req_wen, 0);
            chk("tbl_res_valid0", res_valid0, tbl[i].e_rv0);
            chk("tbl_res_valid1", res_valid1, tbl[i].e_rv1);
            chk("tbl_rdata0", res_rdata0, tbl[i].e_rd0);
            req_valid0 = tbl[i].rv0; req_addr0 = tbl[i].a0; req_wen0 = 1'b0;
            mem_res_valid = tbl[i].mrv; mem_rdata = tbl[i].mrd;
            step();
        end

        // Simultaneous requests after reset: port 0 wins the first tie
        do_reset();
        req_valid0 = 1; req_wen0 = 0; req_addr0 = 32'h200;
        req_valid1 = 1; req_wen1 = 1; req_addr1 = 32'h300; req_wdata1 = 128'h55;
        step();
        chk("sim_busy0", busy0, 1); chk("sim_busy1", busy1, 1);
        serve(0, 32'h200, 0, 0, 128'hA1, 128'hA1);
        chk("sim_nonowner_busy1", busy1, 1);
        serve(1, 32'h300, 1, 128'h55, 128'hBAD, 128'h0);

        // Port 0 alone, with a dropped second pulse while busy
        req_valid0 = 1; req_wen0 = 0; req_addr0 = 32'h220;
        step();
        req_valid0 = 1; req_wen0 = 0; req_addr0 = 32'h400;
        step();
        serve(0, 32'h220, 0, 0, 128'hC2, 128'hC2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drop_no_req", mem_req_valid, 0);
            chk("drop_busy0", busy0, 0);
        end

        // Both again with last grant on port 0: port 1 goes first
        req_valid0 = 1; req_wen0 = 0; req_addr0 = 32'h230;
        req_valid1 = 1; req_wen1 = 1; req_addr1 = 32'h330; req_wdata1 = 128'h66;
        step();
        serve(1, 32'h330, 1, 128'h66, 128'h1234, 128'h0);
        // Pulse in the res_valid1 cycle is captured
        req_valid1 = 1; req_wen1 = 0; req_addr1 = 32'h500;
        step();
        chk("recap_busy1", busy1, 1);
        serve(0, 32'h230, 0, 0, 128'hB0, 128'hB0);
        serve(1, 32'h500, 0, 0, 128'h5A5A, 128'h5A5A);

        // Reset in the middle of WAIT
        req_valid0 = 1; req_wen0 = 0; req_addr0 = 32'h700;
        step();
        wait_req(ok);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("midrst_busy0", busy0, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        step();
        rst = 1'b1;
        step();
        mem_res_valid = 1; mem_rdata = 128'hFF;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("midrst_res_valid0", res_valid0, 0);
            chk("midrst_res_valid1", res_valid1, 0);
            chk("midrst_busy", {busy1, busy0}, 0);
            chk("midrst_mem_req", mem_req_valid, 0);
            step();
        end
        req_valid0 = 1; req_wen0 = 0; req_addr0 = 32'h800;
        step();
        serve(0, 32'h800, 0, 0, 128'h88, 128'h88);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: abort after 8 WAIT cycles
        req_valid0 = 1; req_wen0 = 0; req_addr0 = 32'h900;
        step();
        wait_req(ok);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("tmo_early_res", res_valid0, 0);
        end
        step();
        chk("tmo_res_valid0", res_valid0, 1);
        chk("tmo_err0", res_err0, 1);
        chk("tmo_rdata0", res_rdata0, 0);
        chk("tmo_busy0", busy0, 0);
        mem_res_valid = 1; mem_rdata = 128'hEE;
        step();
        chk("tmo_late_res0", res_valid0, 0);
        chk("tmo_late_res1", res_valid1, 0);
        // Response on the limit cycle wins as a normal completion
        req_valid0 = 1; req_wen0 = 0; req_addr0 = 32'h910;
        step();
        wait_req(ok);
        repeat (8) step();
        mem_res_valid = 1; mem_rdata = 128'h77;
        step();
        chk("tmo_edge_res_valid0", res_valid0, 1);
        chk("tmo_edge_err0", res_err0, 0);
        chk("tmo_edge_rdata0", res_rdata0, 128'h77);
`endif

        // Randomized traffic against the transaction-level model
        do_reset();
        for (int p = 0; p < 2; p++) begin
            m_vld[p] = 0; m_cap[p] = 0; m_rd[p] = '0; m_resv[p] = 0;
        end
        m_last = 1; outst = 0; free_from = 0; own = 0; resp_at = 0;
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                chk("rnd_busy", get_busy(p), m_vld[p]);
                chk("rnd_res_valid", get_rv(p), m_resv[p]);
                chk("rnd_rdata", get_rd(p), m_rd[p]);
                chk("rnd_err", get_err(p), 0);
            end
            el0 = m_vld[0] && (m_cap[0] <= n - 2);
            el1 = m_vld[1] && (m_cap[1] <= n - 2);
            exp_req = !outst && (n >= free_from) && (el0 || el1);
            chk("rnd_mem_req", mem_req_valid, exp_req);
            if (mem_req_valid && exp_req) begin
                own = (el0 && el1) ? 1 - m_last : (el0 ? 0 : 1);
                m_last = own;
                chk("rnd_mem_addr", mem_addr, m_addr[own]);
                chk("rnd_mem_wen", mem_req_wen, m_wen[own]);
                chk("rnd_mem_wdata", mem_wdata, m_wdata[own]);
                outst = 1;
                resp_at = n + $urandom_range(1, 4);
            end
            m_resv[0] = 0; m_resv[1] = 0;
            if ($urandom_range(0, 3) == 0) begin
                req_valid0 = 1; req_wen0 = 1'($urandom_range(0, 1)); req_addr0 = $urandom;
                req_wdata0 = {$urandom, $urandom, $urandom, $urandom};
                if (!m_vld[0]) begin
                    m_vld[0] = 1; m_cap[0] = n; m_wen[0] = req_wen0;
                    m_addr[0] = req_addr0; m_wdata[0] = req_wdata0;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                req_valid1 = 1; req_wen1 = 1'($urandom_range(0, 1)); req_addr1 = $urandom;
                req_wdata1 = {$urandom, $urandom, $urandom, $urandom};
                if (!m_vld[1]) begin
                    m_vld[1] = 1; m_cap[1] = n; m_wen[1] = req_wen1;
                    m_addr[1] = req_addr1; m_wdata[1] = req_wdata1;
                end
            end
            if (outst && n == resp_at) begin
                mem_res_valid = 1;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                m_resv[own] = 1;
                if (!m_wen[own]) m_rd[own] = mem_rdata;
                m_vld[own] = 0;
                outst = 0;
                free_from = n + 2;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
